jkff_op_arbiter: RTL and testbench

Shares a single JK flip-flop state bit among `N_REQ` requesters, each submitting a 2-bit {J,K} operation. A free-running prescaler produces a slow tick, and an arbiter grants requesters round-robin. The granted operation is applied to Q/Qbar on the next tick, and the winner then receives a one-cycle done pulse. The block sits between board-level command sources (buttons, switches, test logic) and the visible JK state on the FPGA.

---
 rtl/jkff_pkg.sv | 34 +++
 rtl/tick_prescaler.sv | 34 +++
 rtl/jkff_op_arbiter.sv | 120 ++++++++++++
 tb/tb_jkff_op_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jkff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jkff_pkg
// Description : JK operation codes, arbiter FSM states and the JK apply helper.
// Revision    : 1.0 - initial release
// ============================================================================
package jkff_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } jk_state_e;

  // Next Q for a {J,K} operation applied to the current Q.
  function automatic logic jk_apply(input logic q, input logic [1:0] jk);
    logic q_new;
    case (jk)
      JK_HOLD:   q_new = q;
      JK_RESET:  q_new = 1'b0;
      JK_SET:    q_new = 1'b1;
      JK_TOGGLE: q_new = ~q;
      default:   q_new = q;
    endcase
    return q_new;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divider; one-cycle tick every TICK_DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic Clk,
  input  logic Rst,
  output logic tick
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_count <= '0;
    end else if (r_count == c_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_one;
    end
  end

  assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/jkff_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jkff_op_arbiter
// Description : Round-robin arbiter sharing one JK flip-flop; ops applied on tick.
// Revision    : 1.0 - initial release
// ============================================================================
module jkff_op_arbiter
  import jkff_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] op,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic               tick,
  output logic               Q,
  output logic               Qbar
);

  localparam int c_idx_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  jk_state_e          r_state, w_state_nxt;
  logic [c_idx_w-1:0] r_sel, w_sel_nxt;
  logic [c_idx_w-1:0] r_last, w_last_nxt;
  logic [1:0]         r_op, w_op_nxt;
  logic               r_q, w_q_nxt;
  logic [c_idx_w-1:0] w_rr_sel;
  logic               w_any_req;
  logic               w_tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .Clk  (Clk),
    .Rst  (Rst),
    .tick (w_tick)
  );

  // Scan from farthest to nearest offset so the requester right after the
  // last owner overwrites any lower-priority candidate.
  always_comb begin
    int idx;
    idx       = 0;
    w_rr_sel  = r_last;
    w_any_req = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(r_last) + k) % N_REQ;
      if (req[idx]) begin
        w_rr_sel  = c_idx_w'(idx);
        w_any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_last  <= c_idx_w'(N_REQ - 1);
      r_op    <= JK_HOLD;
      r_q     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_op    <= w_op_nxt;
      r_q     <= w_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_op_nxt    = r_op;
    w_q_nxt     = r_q;
    case (r_state)
      IDLE: begin
        // A tick landing here is deliberately ignored.
        if (w_any_req) begin
          w_sel_nxt   = w_rr_sel;
          w_op_nxt    = op[{w_rr_sel, 1'b0} +: 2];
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_tick) begin
          w_q_nxt     = jk_apply(r_q, r_op);
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_last_nxt  = r_sel;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_onehot
    assign grant[i] = (r_state == WAIT) && (r_sel == c_idx_w'(i));
    assign done[i]  = (r_state == DONE) && (r_sel == c_idx_w'(i));
  end

  assign busy = (r_state == WAIT);
  assign tick = w_tick;
  assign Q    = r_q;
  assign Qbar = ~r_q;

endmodule
`default_nettype wire

// File: tb/tb_jkff_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_jkff_op_arbiter
// Description : Scoreboard bench for jkff_op_arbiter with a cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jkff_op_arbiter;

  localparam int N_REQ    = 4;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 2;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] op  = '0;
  logic [3:0] grant;
  logic [3:0] done;
  logic       busy;
  logic       tick;
  logic       Q;
  logic       Qbar;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int   who;
    logic q;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model: transaction-level view of owner, phase and shared bit.
  int   m_cnt;
  int   m_owner;
  int   m_last;
  int   m_done_who;
  bit   m_in_done;
  logic m_q;
  logic [1:0] m_op;

  jkff_op_arbiter #(
    .N_REQ    (N_REQ),
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .req   (req),
    .op    (op),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .tick  (tick),
    .Q     (Q),
    .Qbar  (Qbar)
  );

  always #5 Clk = ~Clk;

  function automatic logic [3:0] onehot(input int i);
    return (i < 0) ? 4'b0 : 4'(1 << i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt      = 0;
    m_owner    = -1;
    m_last     = N_REQ - 1;
    m_done_who = 0;
    m_in_done  = 1'b0;
    m_q        = 1'b0;
    m_op       = 2'b00;
    sb.delete();
  endtask

  // Advance the model across one rising edge using the inputs just driven.
  task automatic model_step();
    bit   tick_now;
    logic j, k;
    tick_now = (m_cnt == TICK_DIV - 1);
    if (m_in_done) begin
      m_in_done = 1'b0;
      m_last    = m_done_who;
    end else if (m_owner >= 0) begin
      if (tick_now) begin
        j   = m_op[1];
        k   = m_op[0];
        m_q = (j & !m_q) | (!k & m_q);
        sb.push_back('{m_owner, m_q});
        m_in_done  = 1'b1;
        m_done_who = m_owner;
        m_owner    = -1;
      end
    end else begin
      for (int n = 1; n <= N_REQ; n++) begin
        int c;
        c = (m_last + n) % N_REQ;
        if (req[c]) begin
          m_owner = c;
          m_op    = op[2*c +: 2];
          break;
        end
      end
    end
    m_cnt = (m_cnt + 1) % TICK_DIV;
  endtask

  task automatic check_outputs();
    check("grant", 32'(grant), 32'(onehot(m_owner)));
    check("busy",  32'(busy),  32'(m_owner >= 0));
    check("tick",  32'(tick),  32'(m_cnt == TICK_DIV - 1));
    check("done",  32'(done),  32'(m_in_done ? onehot(m_done_who) : 4'b0));
    check("Q",     32'(Q),     32'(m_q));
    check("Qbar",  32'(Qbar),  32'(!m_q));
  endtask

  task automatic cyc(input logic [3:0] r, input logic [7:0] o);
    @(negedge Clk);
    check_outputs();
    req = r;
    op  = o;
    model_step();
  endtask

  // Reset lands between edges so its effect must be asynchronous.
  task automatic do_reset_async();
    @(negedge Clk);
    check_outputs();
    #1 Rst = 1'b1;
    #1;
    check("rst_Q",     32'(Q),     32'h0);
    check("rst_Qbar",  32'(Qbar),  32'h1);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_done",  32'(done),  32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_tick",  32'(tick),  32'h0);
    check("rst_count", 32'(dut.u_prescaler.r_count), 32'h0);
    #1 Rst = 1'b0;
    req = '0;
    op  = '0;
    model_reset();
    model_step();
  endtask

  task automatic run_op(input logic [3:0] r_first, input logic [7:0] o_first,
                        input logic [3:0] r_rest,  input logic [7:0] o_rest);
    int n;
    cyc(r_first, o_first);
    n = 0;
    while (!m_in_done && n < 40) begin
      cyc(r_rest, o_rest);
      n++;
    end
    check("op_completes", 32'(m_in_done), 32'h1);
    cyc(4'b0, 8'b0);
  endtask

  always @(negedge Clk) begin
    if (done !== 4'b0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done: got %0h expected none at %0t", done, $time);
      end else begin
        mon_e = sb.pop_front();
        check("sb_done_who", 32'(done), 32'(onehot(mon_e.who)));
        check("sb_done_q",   32'(Q),    32'(mon_e.q));
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic [7:0] o;
    int n;

    model_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check_outputs();
    Rst = 1'b0;
    model_step();

    cyc(4'b0, 8'b0);
    cyc(4'b0, 8'b0);
    do_reset_async();

    run_op(4'b0001, 8'b0000_0010, 4'b0001, 8'b0000_0010);
    run_op(4'b0001, 8'b0000_0011, 4'b0001, 8'b0000_0011);
    run_op(4'b0001, 8'b0000_0010, 4'b0000, 8'b0000_0001);
    run_op(4'b0001, 8'b0000_0000, 4'b0001, 8'b0000_0000);

    repeat (40) cyc(4'hF, 8'hFF);

    n = 0;
    while ((m_owner >= 0 || m_in_done) && n < 20) begin
      cyc(4'b0, 8'b0);
      n++;
    end
    cyc(4'b0100, 8'hAA);
    do_reset_async();
    repeat (8) cyc(4'hF, 8'hFF);

    r = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (m_in_done && m_done_who == i) begin
          r[i] = 1'($urandom_range(0, 1));
        end else if (m_owner == i) begin
          if ($urandom_range(0, 7) == 0) r[i] = 1'b0;
        end else if (!r[i]) begin
          r[i] = ($urandom_range(0, 2) == 0);
        end
      end
      o = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        do_reset_async();
        r = '0;
      end else begin
        cyc(r, o);
      end
    end

    repeat (20) cyc(4'b0, 8'b0);
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
